// File: rtl/div_sub_shift_if.sv
// Handshake and operand/result bundle for the shift-subtract divider.
// master: control unit side; slave: divider side.
interface div_sub_shift_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output Start, Dividend, Divisor,
    input  Quotient, Remainder, Busy, Done, DivZero
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Quotient, Remainder, Busy, Done, DivZero
  );
endinterface

// File: rtl/div_sub_shift.sv
// Sequential restoring divider, unsigned WIDTH/WIDTH, one quotient bit per clock.
// Start is taken only in IDLE; a zero divisor completes immediately with DivZero set.
module div_sub_shift #(
  parameter int WIDTH = 16
) (
  input logic           Clk,
  input logic           Rst,
  div_sub_shift_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  // Partial remainder is always < divisor, so WIDTH bits hold it; the guard
  // bit lives in the shifted value that feeds the trial subtraction.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step: trial subtract, keep it if non-negative, else restore.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    t       = r_shift - {1'b0, d};
    r_next  = r_shift[WIDTH-1:0];
    q_next  = {q[WIDTH-2:0], 1'b0};
    if (!t[WIDTH]) begin
      r_next = t[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM with registered Busy/Done and result registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (bus.Start) begin
            if (bus.Divisor != '0) begin
              r        <= '0;
              q        <= bus.Dividend;
              d        <= bus.Divisor;
              cnt      <= '0;
              div_zero <= 1'b0;
              busy     <= 1'b1;
              state    <= CALC;
            end else begin
              // No iteration needed: all-ones quotient, dividend passes through.
              quotient  <= '1;
              remainder <= bus.Dividend;
              div_zero  <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        CALC: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= q_next;
            remainder <= r_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Quotient  = quotient;
  assign bus.Remainder = remainder;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.DivZero   = div_zero;

endmodule

// File: tb/tb_div_sub_shift.sv
// Bench for div_sub_shift: vector table plus corner sequences, results
// checked by a scoreboard queue popped on every Done pulse.
module tb_div_sub_shift;

  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } vec_t;

  logic Clk;
  logic Rst;
  div_sub_shift_if #(.WIDTH(WIDTH)) bus ();

  div_sub_shift #(.WIDTH(WIDTH)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  vec_t sb[$];
  logic [WIDTH-1:0] prev_q = '0;
  logic [WIDTH-1:0] prev_r = '0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every Done pops one expected record.
  always @(negedge Clk) begin
    if (bus.Done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        check("quotient", 32'(bus.Quotient), 32'(e.q));
        check("remainder", 32'(bus.Remainder), 32'(e.r));
        check("divzero", 32'(bus.DivZero), 32'(e.dz));
        check("busy_with_done", 32'(bus.Busy), 32'd0);
        if (!e.dz) begin
          check("invariant", 32'(bus.Quotient) * 32'(e.b) + 32'(bus.Remainder), 32'(e.a));
          check("rem_lt_div", 32'(bus.Remainder < e.b), 32'd1);
        end
      end
    end
  end

  // Called just after the accepting edge; follows the op to its Done pulse.
  task automatic wait_done(input int exp_lat, input int exp_busy);
    int lat;
    int busy_n;
    bit hold_ok;
    lat = 0;
    busy_n = 0;
    hold_ok = 1'b1;
    while (bus.Done !== 1'b1 && lat < 40) begin
      if (bus.Busy === 1'b1) busy_n++;
      if (bus.Quotient !== prev_q || bus.Remainder !== prev_r) hold_ok = 1'b0;
      @(posedge Clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_n), 32'(exp_busy));
    check("result_hold", 32'(hold_ok), 32'd1);
    @(posedge Clk); #1;
    check("done_pulse", 32'(bus.Done), 32'd0);
  endtask

  task automatic do_op(input vec_t v);
    @(negedge Clk);
    bus.Start    = 1'b1;
    bus.Dividend = v.a;
    bus.Divisor  = v.b;
    sb.push_back(v);
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    if (v.dz) wait_done(0, 0);
    else      wait_done(16, 16);
    prev_q = v.q;
    prev_r = v.r;
  endtask

  vec_t vecs[6];
  vec_t v;
  int done_seen;

  initial begin
    vecs[0] = '{a: 16'd100,    b: 16'd7, q: 16'd14,     r: 16'd2,    dz: 1'b0};
    vecs[1] = '{a: 16'hFFFF,   b: 16'd1, q: 16'hFFFF,   r: 16'd0,    dz: 1'b0};
    vecs[2] = '{a: 16'd5,      b: 16'd9, q: 16'd0,      r: 16'd5,    dz: 1'b0};
    vecs[3] = '{a: 16'd0,      b: 16'd3, q: 16'd0,      r: 16'd0,    dz: 1'b0};
    vecs[4] = '{a: 16'd1234,   b: 16'd0, q: 16'hFFFF,   r: 16'd1234, dz: 1'b1};
    vecs[5] = '{a: 16'd100,    b: 16'd7, q: 16'd14,     r: 16'd2,    dz: 1'b0};

    Rst = 1'b1;
    bus.Start = 1'b0;
    bus.Dividend = '0;
    bus.Divisor = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_quotient", 32'(bus.Quotient), 32'd0);
    check("rst_remainder", 32'(bus.Remainder), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_divzero", 32'(bus.DivZero), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    for (int i = 0; i < 6; i++) do_op(vecs[i]);

    // Reset at edge 8 of a 1000/3 calculation: abort, no Done.
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Dividend = 16'd1000;
    bus.Divisor = 16'd3;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    repeat (7) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    check("abort_quotient", 32'(bus.Quotient), 32'd0);
    check("abort_remainder", 32'(bus.Remainder), 32'd0);
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_divzero", 32'(bus.DivZero), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    prev_q = '0;
    prev_r = '0;
    do_op('{a: 16'd1000, b: 16'd3, q: 16'd333, r: 16'd1, dz: 1'b0});

    // Start held high, operands changed mid-CALC; second op taken at edge 18.
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Dividend = 16'd100;
    bus.Divisor = 16'd7;
    sb.push_back('{a: 16'd100, b: 16'd7, q: 16'd14, r: 16'd2, dz: 1'b0});
    sb.push_back('{a: 16'd5000, b: 16'd13, q: 16'd384, r: 16'd8, dz: 1'b0});
    @(posedge Clk); #1;
    for (int e = 1; e <= 18; e++) begin
      @(posedge Clk); #1;
      if (e == 3) begin
        bus.Dividend = 16'd5000;
        bus.Divisor = 16'd13;
      end
      if (e == 15) check("held_busy_e15", 32'({bus.Busy, bus.Done}), 32'b10);
      if (e == 16) check("held_done_e16", 32'({bus.Busy, bus.Done}), 32'b01);
      if (e == 17) check("held_idle_e17", 32'({bus.Busy, bus.Done}), 32'b00);
      if (e == 18) check("held_accept_e18", 32'({bus.Busy, bus.Done}), 32'b10);
    end
    bus.Start = 1'b0;
    prev_q = 16'd14;
    prev_r = 16'd2;
    wait_done(16, 16);
    prev_q = 16'd384;
    prev_r = 16'd8;

    // Random pairs against the reference model.
    for (int i = 0; i < 500; i++) begin
      v.a = 16'($urandom_range(0, 65535));
      if (i % 4 == 0) v.b = 16'($urandom_range(1, 15));
      else            v.b = 16'($urandom_range(1, 65535));
      v.q = v.a / v.b;
      v.r = v.a % v.b;
      v.dz = 1'b0;
      do_op(v);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
